// File: rtl/interp_pkg.sv
// ============================================================================
// Module      : interp_pkg
// Description : Shared types and helpers for the Farrow interpolator control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package interp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } sched_state_t;

    localparam int MU_FRAC_BITS = 11;

    // Nearest-integer k/phases in Q2.11 (half-up rounding).
    function automatic int unsigned mu_tab(input int unsigned k, input int unsigned phases);
        return (k * (32'd1 << MU_FRAC_BITS) + phases / 2) / phases;
    endfunction

endpackage

`default_nettype wire

// File: rtl/interp_tag_delay.sv
// ============================================================================
// Module      : interp_tag_delay
// Description : LAT-deep shift register carrying {valid, phase} tags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interp_tag_delay #(
    parameter int LAT  = 2,
    parameter int PH_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [PH_W-1:0] phase_i,
    output logic            valid_o,
    output logic [PH_W-1:0] phase_o
);

    logic [LAT-1:0]  valid_q;
    logic [PH_W-1:0] phase_q [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            phase_q[0] <= phase_i;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                phase_q[i] <= phase_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LAT-1];
    assign phase_o = phase_q[LAT-1];

endmodule

`default_nettype wire

// File: rtl/interp_mu_scheduler.sv
// ============================================================================
// Module      : interp_mu_scheduler
// Description : Presents each input sample for PHASES clocks with matching mu
//               and tags the interpolator output stream. Optional underrun
//               status ports under `INTERP_SCHED_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interp_mu_scheduler
    import interp_pkg::*;
#(
    parameter int PHASES = 6,
    parameter int DATA_W = 13,
    parameter int MU_W   = 13,
    parameter int LAT    = 2,
    parameter int PH_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic signed [DATA_W-1:0] x_out,
    output logic                     x_load,
    output logic [MU_W-1:0]          mu_out,
    output logic                     out_valid,
    output logic [PH_W-1:0]          out_phase
`ifdef INTERP_SCHED_STATUS_EN
    ,
    output logic                     underrun,
    output logic [15:0]              underrun_cnt
`endif
);

    localparam logic [PH_W-1:0] c_last_ph = PH_W'(PHASES - 1);
    localparam int              c_rom_n   = 2 ** PH_W;

    sched_state_t    state_q;
    logic [PH_W-1:0] phase_q;
    logic [MU_W-1:0] mu_rom [c_rom_n];

    logic            w_xfer;
    logic            w_iss;
    logic [PH_W-1:0] w_phase_nxt;

    // Constant table padded to the full index range so any phase code is in bounds.
    for (genvar k = 0; k < c_rom_n; k++) begin : g_mu_rom
        if (k < PHASES) begin : g_used
            assign mu_rom[k] = MU_W'(mu_tab(k, PHASES));
        end else begin : g_pad
            assign mu_rom[k] = '0;
        end
    end

    assign w_xfer      = s_valid & s_ready;
    assign w_iss       = (state_q == RUN);
    assign w_phase_nxt = phase_q + PH_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            s_ready <= 1'b1;
            x_out   <= '0;
            x_load  <= 1'b0;
            mu_out  <= '0;
        end else begin
            x_load <= 1'b0;
            if (w_xfer) begin
                state_q <= RUN;
                phase_q <= '0;
                x_out   <= s_data;
                x_load  <= 1'b1;
                mu_out  <= mu_rom[0];
                s_ready <= 1'b0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (phase_q == c_last_ph) begin
                            state_q <= STALL;
                            s_ready <= 1'b1;
                        end else begin
                            phase_q <= w_phase_nxt;
                            mu_out  <= mu_rom[w_phase_nxt];
                            s_ready <= (w_phase_nxt == c_last_ph);
                        end
                    end
                    default: begin
                        // IDLE and STALL keep x/phase/mu and stay ready.
                        s_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    interp_tag_delay #(
        .LAT  (LAT),
        .PH_W (PH_W)
    ) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .valid_i (w_iss),
        .phase_i (phase_q),
        .valid_o (out_valid),
        .phase_o (out_phase)
    );

`ifdef INTERP_SCHED_STATUS_EN
    logic w_underrun_evt;

    assign w_underrun_evt = (state_q == RUN) && (phase_q == c_last_ph) && !w_xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (w_underrun_evt) begin
            underrun <= 1'b1;
            if (underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/interp_mu_scheduler.md
# interp_mu_scheduler

Sequencing controller for the parabolic (Farrow) interpolator datapath. It accepts input samples from upstream over a valid/ready handshake and presents each sample to the interpolator for PHASES consecutive clocks. For each of those clocks it drives the matching fractional delay mu. It also tags the interpolator's output stream with valid and phase flags, aligned to the datapath latency.

## Interface
- PHASES, 6, output samples per input sample (2..8)
- DATA_W, 13, sample width (signed)
- MU_W, 13, mu width (unsigned Q2.11; 2048 = 1.0)
- LAT, 2, interpolator latency in clocks, from x_out/mu_out to output_y (1..8)
- PH_W, 3, phase index width; must be ≥ clog2(PHASES)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- s_data  in  DATA_W  upstream sample (signed)
- s_valid  in  1  s_data valid
- s_ready  out  1  scheduler accepts s_data this cycle
- x_out  out  DATA_W  sample held for the interpolator's input_x
- x_load  out  1  one-cycle pulse: x_out changed this cycle
- mu_out  out  MU_W  fractional delay for the interpolator's mu
- out_valid  out  1  interpolator output_y is a valid point this cycle
- out_phase  out  PH_W  phase index k of that output point

## Operation
- mu table: MU_TAB[k] = round(k·2048/PHASES) for k = 0..PHASES-1.
  - PHASES=6 gives 0, 341, 683, 1024, 1365, 1707.
  - Table values exceed neither 2047 nor MU_W.
- FSM states: IDLE, RUN, STALL. All outputs are registered.
- IDLE
  - s_ready=1.
  - On s_valid: x_out←s_data, x_load←1, phase←0, go to RUN.
- RUN
  - mu_out=MU_TAB[phase].
  - phase increments each clock.
  - s_ready=1 only while phase==PHASES-1.
  - At phase PHASES-1 with s_valid: load the new sample, phase←0, stay in RUN. This is gapless, one sample per PHASES clocks.
  - At phase PHASES-1 without s_valid: go to STALL (underrun).
- STALL
  - x_out, phase and mu_out hold their last values; s_ready=1.
  - On s_valid: load the sample, phase←0, go to RUN.
- Issue flag: iss = (state==RUN). In STALL and IDLE no valid point is issued.
- Tag pipeline: {iss, phase} passes through a LAT-deep shift register and appears as {out_valid, out_phase}.
- Handshake
  - A transfer occurs only when s_valid & s_ready at a rising edge.
  - s_data is sampled only on a transfer.
  - s_valid may be asserted at any time; it is not required to be held.
- phase wraps from PHASES-1 to 0 only on a sample load and never free-runs past PHASES-1.

## Timing
- Reset values: state=IDLE, phase=0, s_ready=1, x_out=0, x_load=0, mu_out=0, out_valid=0, out_phase=0, tag pipeline cleared.
- Sample accepted at edge t:
  - x_out, x_load=1 and mu_out=0 are visible after t.
  - mu_out=MU_TAB[k] is visible after edge t+k.
  - The matching out_valid/out_phase=k is visible after edge t+k+LAT.
- x_load lasts one cycle per accepted sample, including back-to-back loads.
- Reset asserted mid-RUN or mid-STALL returns immediately to the reset values. In-flight tags are discarded and no out_valid follows.
- s_valid in the same cycle as reset deassertion is ignored until the first edge after rst is low.

## Configuration
- INTERP_SCHED_STATUS_EN defined:
  - Adds output underrun (1 bit, sticky; set on each RUN→STALL transition, cleared only by rst).
  - Adds output underrun_cnt (16 bits, saturating at 0xFFFF; increments per RUN→STALL transition; reset 0).
- Undefined: neither port exists and there is no status logic. Core behaviour is identical in both builds.

## Structure
- Shared package interp_pkg holds:
  - the sched_state_t enum {IDLE, RUN, STALL};
  - the MU_FRAC_BITS=11 constant;
  - the function mu_tab(k, phases) returning round(k·2048/phases).
- One sub-module, interp_tag_delay: a parameterised LAT-deep shift register for {valid, phase} with async-reset clear.

## Test plan
- Reset: hold rst for 3 clocks → all outputs at reset values; s_ready=1; out_valid=0.
- Continuous stream 100, -200, 300 with s_valid held high:
  - x_load pulses exactly every 6 clocks;
  - mu_out repeats 0, 341, 683, 1024, 1365, 1707 with no gap;
  - out_valid stays high from LAT clocks after the first load, with out_phase cycling 0..5.
- Underrun: after the first sample, hold s_valid low for 4 clocks beyond phase 5:
  - STALL is entered; mu_out holds 1707; x_out holds;
  - out_valid drops LAT clocks after STALL entry;
  - the next s_valid resumes at mu_out=0.
- Reset asserted at phase 3 of a sample → outputs go to reset values asynchronously; no out_valid appears in the following LAT+2 clocks.
- PHASES=4, LAT=1 → mu_out sequence 0, 512, 1024, 1536; s_ready high 1 clock in 4.
- With INTERP_SCHED_STATUS_EN, three forced underruns → underrun=1 and underrun_cnt=3; rst clears both.
